// File: rtl/piezo_melody_sequencer.sv
// piezo_melody_sequencer: plays a fixed ROM melody as a one-hot tone select, with live-button override
module piezo_melody_sequencer #(
  parameter logic [23:0] BEAT_CYCLES = 24'd250000,
  parameter logic [15:0] GAP_CYCLES  = 16'd5000,
  parameter int          SONG_LEN    = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [7:0] btn_in,
  output logic [7:0] tone_sel,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;
  localparam logic [3:0] LAST = 4'(SONG_LEN - 1);
  state_t state, nxt_state;
  logic [23:0] cnt, nxt_cnt;
  logic [1:0] beat, nxt_beat;
  logic [3:0] nxt_idx;
  logic nxt_done;
  logic [7:0] nxt_tone;
  logic [5:0] cur_entry, nxt_entry;
  function automatic logic [5:0] rom(input logic [3:0] i);
    case (i)
      4'd0, 4'd1:   rom = {4'd1, 2'd0};
      4'd2, 4'd3:   rom = {4'd5, 2'd0};
      4'd4, 4'd5:   rom = {4'd6, 2'd0};
      4'd6:         rom = {4'd5, 2'd1};
      4'd7, 4'd8:   rom = {4'd4, 2'd0};
      4'd9, 4'd10:  rom = {4'd3, 2'd0};
      4'd11, 4'd12: rom = {4'd2, 2'd0};
      4'd13:        rom = {4'd1, 2'd1};
      default:      rom = 6'd0;
    endcase
  endfunction
  function automatic logic [7:0] onehot(input logic [3:0] code);
    onehot = (code != 4'd0 && code <= 4'd8) ? 8'd1 << (code - 4'd1) : 8'd0;
  endfunction
  assign cur_entry = rom(note_idx);
  assign nxt_entry = rom(nxt_idx);
  assign nxt_tone = (btn_in != 8'd0) ? btn_in : (nxt_state == NOTE) ? onehot(nxt_entry[5:2]) : 8'd0;
  assign busy = state != IDLE;
  // Register state, counters and outputs; reset clears everything immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 24'd0;
      beat     <= 2'd0;
      note_idx <= 4'd0;
      done     <= 1'b0;
      tone_sel <= 8'd0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      beat     <= nxt_beat;
      note_idx <= nxt_idx;
      done     <= nxt_done;
      tone_sel <= nxt_tone;
    end
  end
  // Next state: beat timing in NOTE, fixed silence in GAP, stop overrides everything
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_beat  = beat;
    nxt_idx   = note_idx;
    nxt_done  = 1'b0;
    if (stop) begin
      nxt_state = IDLE;
      nxt_cnt   = 24'd0;
      nxt_beat  = 2'd0;
      nxt_idx   = 4'd0;
    end else begin
      case (state)
        IDLE: if (play) begin
          nxt_state = NOTE;
          nxt_cnt   = 24'd0;
          nxt_beat  = 2'd0;
          nxt_idx   = 4'd0;
        end
        NOTE: if (cnt == BEAT_CYCLES - 24'd1) begin
          nxt_cnt   = 24'd0;
          nxt_beat  = (beat == cur_entry[1:0]) ? 2'd0 : beat + 2'd1;
          nxt_state = (beat == cur_entry[1:0]) ? GAP : NOTE;
        end else nxt_cnt = cnt + 24'd1;
        GAP: if (cnt == {8'd0, GAP_CYCLES - 16'd1}) begin
          nxt_cnt   = 24'd0;
          nxt_idx   = (note_idx < LAST) ? note_idx + 4'd1 : 4'd0;
          nxt_state = (note_idx < LAST || loop_en) ? NOTE : IDLE;
          nxt_done  = note_idx >= LAST && !loop_en;
        end else nxt_cnt = cnt + 24'd1;
        default: nxt_state = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piezo_melody_sequencer.sv
// tb_piezo_melody_sequencer: scoreboard bench replaying expected per-edge outputs from an independent song model
module tb_piezo_melody_sequencer;
  typedef struct packed {
    logic [7:0] tone;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, play = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [7:0] btn_in = 8'd0;
  logic [7:0] tone_sel;
  logic busy, done;
  logic [3:0] note_idx;
  int checks = 0, errors = 0;
  string tag = "reset";
  exp_t q[$];
  int codes[14] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1};
  int beats[14] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};
  piezo_melody_sequencer #(.BEAT_CYCLES(24'd10), .GAP_CYCLES(16'd2), .SONG_LEN(14)) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .loop_en(loop_en),
    .btn_in(btn_in), .tone_sel(tone_sel), .busy(busy), .note_idx(note_idx), .done(done)
  );
  always #5 clk = ~clk;
  task automatic push_pass();
    for (int e = 0; e < 14; e++) begin
      for (int c = 0; c < beats[e] * 10; c++) q.push_back({8'd1 << (codes[e] - 1), 4'(e), 1'b1, 1'b0});
      for (int c = 0; c < 2; c++) q.push_back({8'd0, 4'(e), 1'b1, 1'b0});
    end
  endtask
  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back({8'd0, 4'd0, 1'b0, 1'b0});
  endtask
  task automatic push_end();
    q.push_back({8'd0, 4'd0, 1'b0, 1'b1});
    push_idle(2);
  endtask
  task automatic run(input int n);
    exp_t e, o;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      o = {tone_sel, note_idx, busy, done};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL %s: scoreboard empty, observed tone=%h idx=%0d busy=%b done=%b", tag, o.tone, o.idx, o.busy, o.done);
      end else begin
        e = q.pop_front();
        assert (o === e) else begin
          errors++;
          $error("FAIL %s @%0t: tone=%h idx=%0d busy=%b done=%b, expected tone=%h idx=%0d busy=%b done=%b",
                 tag, $time, o.tone, o.idx, o.busy, o.done, e.tone, e.idx, e.busy, e.done);
        end
      end
    end
  endtask
  task automatic check_zero();
    checks++;
    assert ({tone_sel, note_idx, busy, done} === 14'd0) else begin
      errors++;
      $error("FAIL %s: tone=%h idx=%0d busy=%b done=%b, expected all zero", tag, tone_sel, note_idx, busy, done);
    end
  endtask
  task automatic pulse_play();
    play = 1'b1;
    run(1);
    play = 1'b0;
  endtask
  initial begin
    #22;
    check_zero();
    rst = 1'b1;
    push_idle(2);
    run(2);
    tag = "song";
    push_pass();
    push_end();
    pulse_play();
    run(q.size());
    tag = "loop";
    loop_en = 1'b1;
    push_pass();
    push_pass();
    push_end();
    pulse_play();
    run(200);
    loop_en = 1'b0;
    run(q.size());
    tag = "stop";
    push_pass();
    pulse_play();
    run(29);
    stop = 1'b1;
    q.delete();
    push_idle(1);
    run(1);
    tag = "play_stop";
    play = 1'b1;
    push_idle(1);
    run(1);
    play = 1'b0;
    stop = 1'b0;
    push_idle(3);
    run(3);
    tag = "override";
    push_pass();
    push_end();
    pulse_play();
    run(1);
    btn_in = 8'h80;
    for (int i = 0; i < 5; i++) q[i].tone = 8'h80;
    run(5);
    btn_in = 8'h00;
    run(q.size());
    tag = "play_busy";
    push_pass();
    push_end();
    pulse_play();
    run(49);
    play = 1'b1;
    run(1);
    play = 1'b0;
    run(q.size());
    tag = "async_rst";
    push_pass();
    pulse_play();
    run(10);
    #2;
    rst = 1'b0;
    #1;
    check_zero();
    q.delete();
    #2;
    rst = 1'b1;
    push_idle(5);
    run(5);
    tag = "after_rst";
    push_pass();
    push_end();
    pulse_play();
    run(q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
